onehot_encoder_stream: RTL and testbench

- Registered one-hot-to-binary encoder; inverse of the team's 2-to-4 decoder (din 4'b0100 -> dout 2'b10).
- Sits on a valid/ready streaming path. Converts one-hot select words back to a binary index.
- Flags words that are not one-hot and keeps a saturating count of them for debug/status readout.

---
 rtl/onehot_encoder_stream.sv | 69 ++++++
 tb/tb_onehot_encoder_stream.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/onehot_encoder_stream.sv
// onehot_encoder_stream: registered one-hot to binary encoder on a valid/ready stream with error counting
module onehot_encoder_stream #(
    parameter int N         = 4,
    parameter int PRIO_HIGH = 1,
    parameter int CNT_W     = 8,
    localparam int W        = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     din,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [W-1:0]     dout,
    output logic             err,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] err_cnt
);

    logic [W-1:0]     dout_q, dout_d, enc_idx;
    logic             err_q, err_d, enc_err;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept, hit;

    assign in_ready  = !rst && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign enc_err   = (din == '0) || ((din & (din - N'(1))) != '0);
    assign dout      = dout_q;
    assign err       = err_q;
    assign out_valid = out_valid_q;
    assign err_cnt   = cnt_q;

    // Scan bits upward; later set bits overwrite the index only when the highest bit wins
    always_comb begin
        enc_idx = '0;
        hit     = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (din[i] && (PRIO_HIGH != 0 || !hit)) enc_idx = W'(i);
            hit = hit | din[i];
        end
    end

    // Next state: load on accept, drop valid on a bare transfer, hold under backpressure
    always_comb begin
        dout_d      = accept ? enc_idx : dout_q;
        err_d       = accept ? enc_err : err_q;
        out_valid_d = accept || (out_valid_q && !out_ready);
        cnt_d       = cnt_clr ? '0 :
                      (accept && enc_err && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    // State registers with synchronous reset discarding any held result
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q      <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            dout_q      <= dout_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: tb/tb_onehot_encoder_stream.sv
// tb_onehot_encoder_stream: scoreboard bench driving three encoder variants with shared stimulus
module tb_onehot_encoder_stream;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] din = '0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic       cnt_clr = 1'b0;

    logic       rdy_a, rdy_b, rdy_c;
    logic [1:0] dout_a, dout_b, dout_c;
    logic       err_a, err_b, err_c;
    logic       ov_a, ov_b, ov_c;
    logic [7:0] cnt_a, cnt_b;
    logic [1:0] cnt_c;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int hi;
        int lo;
        bit e;
    } exp_t;

    exp_t q[$];
    int   m_cnt_a = 0, m_cnt_b = 0, m_cnt_c = 0;
    bit   prev_rst = 1'b0;

    onehot_encoder_stream #(.N(4), .PRIO_HIGH(1), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .din(din), .in_valid(in_valid), .in_ready(rdy_a),
        .dout(dout_a), .err(err_a), .out_valid(ov_a), .out_ready(out_ready),
        .cnt_clr(cnt_clr), .err_cnt(cnt_a)
    );

    onehot_encoder_stream #(.N(4), .PRIO_HIGH(0), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst), .din(din), .in_valid(in_valid), .in_ready(rdy_b),
        .dout(dout_b), .err(err_b), .out_valid(ov_b), .out_ready(out_ready),
        .cnt_clr(cnt_clr), .err_cnt(cnt_b)
    );

    onehot_encoder_stream #(.N(4), .PRIO_HIGH(1), .CNT_W(2)) dut_c (
        .clk(clk), .rst(rst), .din(din), .in_valid(in_valid), .in_ready(rdy_c),
        .dout(dout_c), .err(err_c), .out_valid(ov_c), .out_ready(out_ready),
        .cnt_clr(cnt_clr), .err_cnt(cnt_c)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic int idx_hi(input logic [3:0] d);
        return (d == 4'd0) ? 0 : $clog2(int'(d) + 1) - 1;
    endfunction

    function automatic int idx_lo(input logic [3:0] d);
        int x;
        x = int'(d) & -int'(d);
        return $clog2(x);
    endfunction

    // Monitor and reference model, evaluated mid-cycle while inputs are stable
    always @(negedge clk) begin
        bit exp_rdy;
        exp_t e;
        exp_rdy = !rst && (q.size() == 0 || out_ready);
        check("in_ready_a", int'(rdy_a), int'(exp_rdy));
        check("in_ready_b", int'(rdy_b), int'(exp_rdy));
        check("in_ready_c", int'(rdy_c), int'(exp_rdy));
        check("out_valid_a", int'(ov_a), int'(q.size() != 0));
        check("out_valid_b", int'(ov_b), int'(q.size() != 0));
        check("out_valid_c", int'(ov_c), int'(q.size() != 0));
        check("err_cnt_a", int'(cnt_a), m_cnt_a);
        check("err_cnt_b", int'(cnt_b), m_cnt_b);
        check("err_cnt_c", int'(cnt_c), m_cnt_c);
        if (prev_rst) begin
            check("rst_dout_a", int'(dout_a), 0);
            check("rst_err_a", int'(err_a), 0);
            check("rst_dout_c", int'(dout_c), 0);
            check("rst_err_b", int'(err_b), 0);
        end
        if (ov_a && q.size() == 0) check("unexpected_output", 1, 0);
        if (ov_a && q.size() != 0) begin
            check("dout_a", int'(dout_a), q[0].hi);
            check("dout_b", int'(dout_b), q[0].lo);
            check("dout_c", int'(dout_c), q[0].hi);
            check("err_a", int'(err_a), int'(q[0].e));
            check("err_b", int'(err_b), int'(q[0].e));
            check("err_c", int'(err_c), int'(q[0].e));
            if (out_ready) void'(q.pop_front());
        end
        if (rst) begin
            q.delete();
            m_cnt_a = 0;
            m_cnt_b = 0;
            m_cnt_c = 0;
        end else begin
            e.hi = idx_hi(din);
            e.lo = idx_lo(din);
            e.e  = $countones(din) != 1;
            if (in_valid && exp_rdy) q.push_back(e);
            if (cnt_clr) begin
                m_cnt_a = 0;
                m_cnt_b = 0;
                m_cnt_c = 0;
            end else if (in_valid && exp_rdy && e.e) begin
                m_cnt_a = (m_cnt_a < 255) ? m_cnt_a + 1 : 255;
                m_cnt_b = (m_cnt_b < 255) ? m_cnt_b + 1 : 255;
                m_cnt_c = (m_cnt_c < 3) ? m_cnt_c + 1 : 3;
            end
        end
        prev_rst = rst;
    end

    task automatic drive(input bit r, input bit v, input logic [3:0] d, input bit ordy, input bit clr);
        rst       = r;
        in_valid  = v;
        din       = d;
        out_ready = ordy;
        cnt_clr   = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] d;
        drive(1, 0, 4'h0, 0, 0);
        drive(1, 0, 4'h0, 0, 0);
        drive(0, 1, 4'b0001, 1, 0);
        drive(0, 1, 4'b0010, 1, 0);
        drive(0, 1, 4'b0100, 1, 0);
        drive(0, 1, 4'b1000, 1, 0);
        drive(0, 1, 4'b0000, 1, 0);
        drive(0, 1, 4'b0110, 1, 0);
        drive(0, 0, 4'b0000, 1, 0);
        drive(0, 1, 4'b0100, 1, 0);
        repeat (3) drive(0, 1, 4'b1000, 0, 0);
        drive(0, 1, 4'b1000, 1, 0);
        drive(0, 0, 4'b0000, 1, 0);
        drive(0, 0, 4'b0000, 1, 1);
        repeat (5) drive(0, 1, 4'b0000, 1, 0);
        drive(0, 1, 4'b0000, 1, 1);
        drive(0, 0, 4'b0000, 1, 0);
        drive(0, 1, 4'b0000, 1, 0);
        drive(0, 0, 4'b0000, 0, 0);
        drive(1, 0, 4'b0000, 0, 0);
        drive(0, 0, 4'b0000, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            d = ($urandom_range(0, 1) != 0) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom);
            drive($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, d,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0);
        end
        drive(0, 0, 4'b0000, 1, 0);
        drive(0, 0, 4'b0000, 1, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
